// File: rtl/stk_pipe_adm.sv
// stk_pipe_adm -- admission/dispatch stage at the head of the stack pipeline.
//
// Engines issue PUSH/POP/INV commands. Each accepted command is buffered in a
// per-class FIFO. The FIFO heads are arbitrated into a registered LK microcode
// stream, and at most one op is kept in flight per engine.
//
// Ports
//   clk, arst                  clock, async active-high reset
//   i_cmd_vld/opcode/dat       per-engine command request (packed per engine)
//   o_cmd_ack                  one-hot combinational accept
//   o_lk_*                     registered microcode output, valid one cycle after issue
//   i_al_empty, i_al_busy      allocator backpressure; o_al_alloc_req on PUSH issue
//   i_rsp_vld                  per-engine completion, clears o_active
//   o_active, o_busy           in-flight flags, stage-not-idle indication

package stk_pkg;
    localparam int OPCODE_W = 2;
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_INV  = 2'd3
    } opcode_t;
endpackage

// Class FIFO. The full and empty flags are registered, so an entry written in
// one cycle can first be read in the next cycle.
module stk_adm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             do_wr, do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        cnt_nxt = cnt;
        if (do_wr && !do_rd)      cnt_nxt = cnt + CNT_W'(1);
        else if (do_rd && !do_wr) cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == CNT_W'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
endmodule

module stk_pipe_adm
    import stk_pkg::*;
#(
    parameter int ENGS_N   = 4,
    parameter int DAT_W    = 128,
    parameter int QDEPTH   = 4,
    parameter int INV_EN   = 1,
    parameter int ARB_MODE = 0,
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic [ENGS_N-1:0]                i_cmd_vld,
    input  logic [ENGS_N-1:0][OPCODE_W-1:0]  i_cmd_opcode,
    input  logic [ENGS_N-1:0][DAT_W-1:0]     i_cmd_dat,
    output logic [ENGS_N-1:0]                o_cmd_ack,
    output logic                             o_lk_vld,
    output logic [ENGID_W-1:0]               o_lk_engid,
    output logic [OPCODE_W-1:0]              o_lk_opcode,
    output logic                             o_lk_dat_vld,
    output logic [DAT_W-1:0]                 o_lk_dat,
    input  logic                             i_al_empty,
    input  logic                             i_al_busy,
    output logic                             o_al_alloc_req,
    input  logic [ENGS_N-1:0]                i_rsp_vld,
    output logic [ENGS_N-1:0]                o_active,
    output logic                             o_busy
);
    localparam int NCLS   = 3;
    localparam int C_PUSH = 0;
    localparam int C_POP  = 1;
    localparam int C_INV  = 2;

    logic [ENGS_N-1:0]               elig, active_q, active_nxt;
    logic [ENGID_W-1:0]              eng_ptr, eng_gnt;
    logic                            eng_found;
    logic [OPCODE_W-1:0]             gnt_op;
    logic [NCLS-1:0]                 fifo_full, fifo_empty, fifo_wr, fifo_rd, deq_req;
    logic [NCLS-1:0][ENGID_W-1:0]    head_eng;
    logic [DAT_W-1:0]                head_dat;
    logic [1:0]                      cls_ptr, cls_gnt;
    logic                            cls_found, issue;
    logic [ENGID_W-1:0]              iss_eng;
    logic [OPCODE_W-1:0]             iss_op;

    // ---------------- enqueue: eligibility + engine round-robin ----------------
    always_comb begin
        elig = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            case (i_cmd_opcode[i])
                OP_PUSH: elig[i] = i_cmd_vld[i] & ~fifo_full[C_PUSH];
                OP_POP:  elig[i] = i_cmd_vld[i] & ~fifo_full[C_POP];
                OP_INV:  elig[i] = (INV_EN != 0) & i_cmd_vld[i] & ~fifo_full[C_INV];
                default: elig[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        int idx;
        eng_found = 1'b0;
        eng_gnt   = '0;
        idx       = 0;
        for (int k = 0; k < ENGS_N; k++) begin
            idx = (int'(eng_ptr) + k) % ENGS_N;
            if (!eng_found && elig[idx]) begin
                eng_found = 1'b1;
                eng_gnt   = ENGID_W'(idx);
            end
        end
    end

    always_comb begin
        o_cmd_ack = '0;
        fifo_wr   = '0;
        gnt_op    = i_cmd_opcode[eng_gnt];
        if (eng_found) begin
            o_cmd_ack[eng_gnt] = 1'b1;
            case (gnt_op)
                OP_PUSH: fifo_wr[C_PUSH] = 1'b1;
                OP_POP:  fifo_wr[C_POP]  = 1'b1;
                OP_INV:  fifo_wr[C_INV]  = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- class FIFOs ----------------
    for (genvar c = 0; c < NCLS; c++) begin : g_cls
        if (c == C_PUSH) begin : g_push
            logic [ENGID_W+DAT_W-1:0] rd_ent;
            stk_adm_fifo #(.W(ENGID_W + DAT_W), .DEPTH(QDEPTH)) u_fifo (
                .clk(clk), .arst(arst),
                .wr_en(fifo_wr[c]), .wr_dat({eng_gnt, i_cmd_dat[eng_gnt]}),
                .rd_en(fifo_rd[c]), .rd_dat(rd_ent),
                .full(fifo_full[c]), .empty(fifo_empty[c])
            );
            assign head_eng[c] = rd_ent[ENGID_W+DAT_W-1:DAT_W];
            assign head_dat    = rd_ent[DAT_W-1:0];
        end else if (c == C_POP || INV_EN != 0) begin : g_ctl
            stk_adm_fifo #(.W(ENGID_W), .DEPTH(QDEPTH)) u_fifo (
                .clk(clk), .arst(arst),
                .wr_en(fifo_wr[c]), .wr_dat(eng_gnt),
                .rd_en(fifo_rd[c]), .rd_dat(head_eng[c]),
                .full(fifo_full[c]), .empty(fifo_empty[c])
            );
        end else begin : g_none
            // No INV storage: looks permanently full so INV is never accepted.
            assign fifo_full[c]  = 1'b1;
            assign fifo_empty[c] = 1'b1;
            assign head_eng[c]   = '0;
        end
    end

    // ---------------- dequeue: per-class request + class arbitration ----------------
    // Each class is gated only by its own head, so a stalled head never blocks
    // another class.
    always_comb begin
        for (int c = 0; c < NCLS; c++)
            deq_req[c] = ~fifo_empty[c] & ~active_q[head_eng[c]];
        deq_req[C_PUSH] = deq_req[C_PUSH] & ~i_al_empty;
    end

    always_comb begin
        int idx;
        cls_found = 1'b0;
        cls_gnt   = '0;
        idx       = 0;
        if (ARB_MODE != 0) begin
            cls_found = |deq_req;
            if (deq_req[C_INV])      cls_gnt = 2'(C_INV);
            else if (deq_req[C_POP]) cls_gnt = 2'(C_POP);
            else                     cls_gnt = 2'(C_PUSH);
        end else begin
            for (int k = 0; k < NCLS; k++) begin
                idx = (int'(cls_ptr) + k) % NCLS;
                if (!cls_found && deq_req[idx]) begin
                    cls_found = 1'b1;
                    cls_gnt   = 2'(idx);
                end
            end
        end
    end

    assign issue   = cls_found & ~i_al_busy;
    assign iss_eng = head_eng[cls_gnt];
    assign iss_op  = (cls_gnt == 2'(C_PUSH)) ? OP_PUSH :
                     (cls_gnt == 2'(C_POP))  ? OP_POP  : OP_INV;

    always_comb begin
        fifo_rd = '0;
        if (issue) fifo_rd[cls_gnt] = 1'b1;
    end

    assign o_al_alloc_req = issue & (cls_gnt == 2'(C_PUSH));

    // A new issue wins over a same-cycle completion on the same engine.
    always_comb begin
        active_nxt = active_q & ~i_rsp_vld;
        if (issue) active_nxt[iss_eng] = 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            eng_ptr      <= '0;
            cls_ptr      <= '0;
            active_q     <= '0;
            o_lk_vld     <= 1'b0;
            o_lk_engid   <= '0;
            o_lk_opcode  <= '0;
            o_lk_dat_vld <= 1'b0;
            o_lk_dat     <= '0;
        end else begin
            active_q     <= active_nxt;
            o_lk_vld     <= issue;
            o_lk_dat_vld <= o_al_alloc_req;
            if (eng_found)
                eng_ptr <= (eng_gnt == ENGID_W'(ENGS_N - 1)) ? '0 : eng_gnt + ENGID_W'(1);
            if (issue) begin
                cls_ptr     <= (cls_gnt == 2'(NCLS - 1)) ? '0 : cls_gnt + 2'd1;
                o_lk_engid  <= iss_eng;
                o_lk_opcode <= iss_op;
            end
            // The payload register keeps the last PUSH data across other ops.
            if (o_al_alloc_req) o_lk_dat <= head_dat;
        end
    end

    assign o_active = active_q;
    assign o_busy   = ~(&fifo_empty) | (|active_q);

    // A completion must target an engine that actually has an op in flight.
    a_rsp_active : assert property (@(posedge clk) disable iff (arst)
                                    (i_rsp_vld & ~active_q) == '0);
endmodule

// File: tb/tb_stk_pipe_adm.sv
// Testbench for stk_pipe_adm: table vectors for acceptance, directed multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_stk_pipe_adm;
    import stk_pkg::*;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int QD = 4;

    logic                 clk = 1'b0, arst = 1'b0;
    logic [N-1:0]         cmd_vld, fp_vld, rsp, fp_rsp;
    logic [N-1:0][1:0]    cmd_op;
    logic [N-1:0][DW-1:0] cmd_dat;
    logic                 al_empty, al_busy;
    logic [N-1:0]         ack, active, fp_ack, fp_active;
    logic                 lk_vld, lk_dat_vld, alloc, busy;
    logic                 fp_lk_vld, fp_lk_dat_vld, fp_alloc, fp_busy;
    logic [1:0]           lk_engid, lk_op, fp_lk_engid, fp_lk_op;
    logic [DW-1:0]        lk_dat, fp_lk_dat;

    always #5 clk = ~clk;

    stk_pipe_adm #(.ENGS_N(N), .DAT_W(DW), .QDEPTH(QD), .INV_EN(1), .ARB_MODE(0)) u_dut (
        .clk(clk), .arst(arst), .i_cmd_vld(cmd_vld), .i_cmd_opcode(cmd_op), .i_cmd_dat(cmd_dat),
        .o_cmd_ack(ack), .o_lk_vld(lk_vld), .o_lk_engid(lk_engid), .o_lk_opcode(lk_op),
        .o_lk_dat_vld(lk_dat_vld), .o_lk_dat(lk_dat), .i_al_empty(al_empty), .i_al_busy(al_busy),
        .o_al_alloc_req(alloc), .i_rsp_vld(rsp), .o_active(active), .o_busy(busy));

    // Fixed-priority variant, only stimulated in the arbitration-order test.
    stk_pipe_adm #(.ENGS_N(N), .DAT_W(DW), .QDEPTH(QD), .INV_EN(1), .ARB_MODE(1)) u_fp (
        .clk(clk), .arst(arst), .i_cmd_vld(fp_vld), .i_cmd_opcode(cmd_op), .i_cmd_dat(cmd_dat),
        .o_cmd_ack(fp_ack), .o_lk_vld(fp_lk_vld), .o_lk_engid(fp_lk_engid), .o_lk_opcode(fp_lk_op),
        .o_lk_dat_vld(fp_lk_dat_vld), .o_lk_dat(fp_lk_dat), .i_al_empty(al_empty), .i_al_busy(al_busy),
        .o_al_alloc_req(fp_alloc), .i_rsp_vld(fp_rsp), .o_active(fp_active), .o_busy(fp_busy));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_vld = '0; fp_vld = '0; rsp = '0; fp_rsp = '0; cmd_op = '0;
    endtask

    task automatic do_reset();
        idle();
        al_empty = 1'b0; al_busy = 1'b0; cmd_dat = '0;
        arst = 1'b1;
        tick(); tick();
        arst = 1'b0;
    endtask

    task automatic chk_lk(input string nm, input int eng, input logic [1:0] op, input logic [DW-1:0] dat);
        chk({nm, ".vld"}, lk_vld, 1);
        chk({nm, ".eng"}, lk_engid, eng);
        chk({nm, ".op"}, lk_op, op);
        chk({nm, ".datvld"}, lk_dat_vld, op == OP_PUSH);
        chk({nm, ".dat"}, lk_dat, dat);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int eng; logic [DW-1:0] dat; } ent_t;
    ent_t          mq [3][$];
    bit            m_act [N];
    int            m_eptr, m_cptr;
    bit            e_vld;
    int            e_eng;
    logic [1:0]    e_op;
    logic [DW-1:0] e_dat;

    function automatic int cls_of(input logic [1:0] op);
        case (op)
            OP_PUSH: return 0;
            OP_POP:  return 1;
            OP_INV:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [1:0] op_of(input int c);
        return (c == 0) ? OP_PUSH : (c == 1) ? OP_POP : OP_INV;
    endfunction

    typedef struct {
        logic [N-1:0] vld;
        logic [7:0]   ops;
        logic [N-1:0] exp_ack;
        logic         exp_busy;
    } vec_t;

    initial begin
        vec_t vt[7];
        vt[0] = '{4'b0100, 8'b01_01_01_01, 4'b0100, 1'b1};
        vt[1] = '{4'b1111, 8'b00_00_00_00, 4'b0000, 1'b0};
        vt[2] = '{4'b1111, 8'b11_10_00_00, 4'b0100, 1'b1};
        vt[3] = '{4'b1010, 8'b11_01_11_01, 4'b0010, 1'b1};
        vt[4] = '{4'b0000, 8'b01_01_01_01, 4'b0000, 1'b0};
        vt[5] = '{4'b1001, 8'b10_00_00_00, 4'b1000, 1'b1};
        vt[6] = '{4'b0011, 8'b00_00_01_10, 4'b0001, 1'b1};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst.lk_vld", lk_vld, 0);   chk("rst.active", active, 0);
        chk("rst.busy", busy, 0);       chk("rst.ack", ack, 0);
        chk("rst.alloc", alloc, 0);     chk("rst.lk_dat", lk_dat, 0);
        chk("rst.lk_eng", lk_engid, 0); chk("rst.lk_datvld", lk_dat_vld, 0);

        // ---- table: single-cycle acceptance from the reset state ----
        for (int v = 0; v < 7; v++) begin
            logic [7:0] o;
            do_reset();
            o = vt[v].ops;
            cmd_vld = vt[v].vld;
            for (int i = 0; i < N; i++) cmd_op[i] = o[2*i +: 2];
            @(negedge clk);
            chk($sformatf("tab%0d.ack", v), ack, vt[v].exp_ack);
            tick(); idle();
            @(negedge clk);
            chk($sformatf("tab%0d.busy", v), busy, vt[v].exp_busy);
        end

        // ---- T1: single PUSH end to end ----
        do_reset();
        cmd_vld[2] = 1'b1; cmd_op[2] = OP_PUSH; cmd_dat[2] = 32'hA5;
        @(negedge clk);
        chk("t1.ack", ack, 4'b0100); chk("t1.alloc0", alloc, 0);
        tick(); idle();
        @(negedge clk);
        chk("t1.alloc1", alloc, 1); chk("t1.lkvld1", lk_vld, 0); chk("t1.busy", busy, 1);
        tick();
        @(negedge clk);
        chk_lk("t1.lk", 2, OP_PUSH, 32'hA5); chk("t1.active", active, 4'b0100);
        tick();
        @(negedge clk);
        chk("t1.lkvld3", lk_vld, 0); chk("t1.datvld3", lk_dat_vld, 0); chk("t1.dathold", lk_dat, 32'hA5);
        tick(); rsp[2] = 1'b1;
        tick(); rsp = '0;
        @(negedge clk);
        chk("t1.active_clr", active, 0); chk("t1.idle", busy, 0);

        // ---- T2: FIFO fill under allocator stall ----
        do_reset();
        al_busy = 1'b1; cmd_vld = '1;
        for (int i = 0; i < N; i++) begin cmd_op[i] = OP_PUSH; cmd_dat[i] = DW'(i + 1); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t2.ack%0d", c), ack, (c < 4) ? (4'b0001 << c) : 4'b0000);
            tick();
        end
        al_busy = 1'b0;
        @(negedge clk);
        chk("t2.full_ack", ack, 0); chk("t2.alloc", alloc, 1);
        tick();
        @(negedge clk);
        chk("t2.reack", ack, 4'b0001); chk("t2.lkeng", lk_engid, 0); chk("t2.lkvld", lk_vld, 1);
        tick(); idle();

        // ---- T3: POP held behind the engine's in-flight PUSH ----
        do_reset();
        cmd_vld[1] = 1'b1; cmd_op[1] = OP_PUSH; cmd_dat[1] = 32'h11;
        tick(); cmd_op[1] = OP_POP;
        @(negedge clk);
        chk("t3.popack", ack, 4'b0010); chk("t3.pushiss", alloc, 1);
        tick(); idle();
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("t3.hold%0d", c), {lk_vld, active}, (c == 2) ? 5'b1_0010 : 5'b0_0010);
            tick();
        end
        rsp[1] = 1'b1;
        @(negedge clk);
        chk("t3.rspcyc", alloc, 0);
        tick(); rsp = '0;
        @(negedge clk);
        chk("t3.cleared", active, 0); chk("t3.lk_none", lk_vld, 0);
        tick();
        @(negedge clk);
        chk_lk("t3.pop", 1, OP_POP, 32'h11); chk("t3.active", active, 4'b0010);

        // ---- T4: class arbitration order, fixed priority vs round-robin ----
        do_reset();
        al_busy = 1'b1;
        cmd_op[0] = OP_INV; cmd_op[1] = OP_POP; cmd_op[2] = OP_PUSH;
        cmd_dat[2] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            cmd_vld = 4'(1 << i); fp_vld = 4'(1 << i);
            @(negedge clk);
            chk($sformatf("t4.ack%0d", i), {fp_ack, ack}, {2{4'(1 << i)}});
            tick();
        end
        cmd_vld = '0; fp_vld = '0; al_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("t4.fp%0d", i), {fp_lk_vld, fp_lk_op, fp_lk_engid},
                {1'b1, (i == 0) ? OP_INV : (i == 1) ? OP_POP : OP_PUSH, 2'(i)});
            chk($sformatf("t4.rr%0d", i), {lk_vld, lk_op, lk_engid},
                {1'b1, (i == 0) ? OP_PUSH : (i == 1) ? OP_POP : OP_INV, 2'(2 - i)});
        end

        // ---- T5: PUSH held on allocator empty, POP bypasses ----
        do_reset();
        al_empty = 1'b1; al_busy = 1'b1;
        cmd_vld[0] = 1'b1; cmd_op[0] = OP_PUSH; cmd_dat[0] = 32'h77;
        tick(); idle(); cmd_vld[3] = 1'b1; cmd_op[3] = OP_POP;
        tick(); idle(); al_busy = 1'b0;
        @(negedge clk);
        chk("t5.alloc2", alloc, 0);
        tick();
        @(negedge clk);
        chk_lk("t5.pop", 3, OP_POP, 32'h0); chk("t5.alloc3", alloc, 0);
        tick();
        @(negedge clk);
        chk("t5.hold", {lk_vld, alloc}, 2'b00);
        tick(); al_empty = 1'b0;
        @(negedge clk);
        chk("t5.alloc5", alloc, 1);
        tick();
        @(negedge clk);
        chk_lk("t5.push", 0, OP_PUSH, 32'h77);

        // ---- T6: reset mid-operation ----
        do_reset();
        cmd_vld[0] = 1'b1; cmd_op[0] = OP_PUSH;
        tick(); idle(); cmd_vld[1] = 1'b1; cmd_op[1] = OP_POP;
        tick(); idle();
        tick(); al_busy = 1'b1; cmd_vld[2] = 1'b1; cmd_op[2] = OP_PUSH;
        tick(); idle(); cmd_vld[3] = 1'b1; cmd_op[3] = OP_INV;
        tick(); idle(); cmd_vld[2] = 1'b1; cmd_op[2] = OP_POP;
        tick(); idle();
        @(negedge clk);
        chk("t6.pre", {busy, active}, 5'b1_0011);
        tick(); arst = 1'b1;
        @(negedge clk);
        chk("t6.rst", {lk_vld, active, busy, ack}, '0);
        tick(); arst = 1'b0; al_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t6.quiet%0d", c), {lk_vld, alloc, busy, active}, '0);
            tick();
        end
        cmd_vld = '1; cmd_op = {N{OP_PUSH}}; cmd_dat[0] = 32'h66;
        @(negedge clk);
        chk("t6.ptr", ack, 4'b0001);
        tick(); idle();
        tick();
        @(negedge clk);
        chk_lk("t6.new", 0, OP_PUSH, 32'h66);

        // ---- randomized traffic against the reference model ----
        do_reset();
        for (int c = 0; c < 3; c++) mq[c].delete();
        for (int i = 0; i < N; i++) m_act[i] = 0;
        m_eptr = 0; m_cptr = 0; e_vld = 0; e_eng = 0; e_op = '0; e_dat = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int   g, gc, ic;
            bit   req [3];
            bit   bz;
            ent_t ent;
            logic [N-1:0] e_act;
            tick();
            al_busy  = ($urandom_range(0, 3) == 0);
            al_empty = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                cmd_vld[i] = 1'($urandom_range(0, 1));
                cmd_op[i]  = 2'($urandom_range(0, 3));
                cmd_dat[i] = DW'($urandom);
                rsp[i]     = m_act[i] && ($urandom_range(0, 2) == 0);
            end
            // admission: first eligible engine at or after the RR pointer
            g = -1; gc = -1;
            for (int k = 0; k < N; k++) begin
                int idx, cl;
                idx = (m_eptr + k) % N;
                cl  = cls_of(cmd_op[idx]);
                if (g < 0 && cmd_vld[idx] && cl >= 0 && mq[cl].size() < QD) begin
                    g = idx; gc = cl;
                end
            end
            // issue: first requesting class at or after the class pointer
            for (int c = 0; c < 3; c++)
                req[c] = mq[c].size() > 0 && !m_act[mq[c][0].eng] && (c != 0 || !al_empty);
            ic = -1;
            if (!al_busy)
                for (int k = 0; k < 3; k++)
                    if (ic < 0 && req[(m_cptr + k) % 3]) ic = (m_cptr + k) % 3;
            bz = 0;
            for (int c = 0; c < 3; c++) if (mq[c].size() > 0) bz = 1;
            for (int i = 0; i < N; i++) begin e_act[i] = m_act[i]; if (m_act[i]) bz = 1; end

            @(negedge clk);
            chk("rnd.ack", ack, (g >= 0) ? (4'b0001 << g) : 4'b0000);
            chk("rnd.alloc", alloc, ic == 0);
            chk("rnd.lk_vld", lk_vld, e_vld);
            chk("rnd.dat_vld", lk_dat_vld, e_vld && e_op == OP_PUSH);
            chk("rnd.lk_dat", lk_dat, e_dat);
            if (e_vld) chk("rnd.lk_id", {lk_op, lk_engid}, {e_op, 2'(e_eng)});
            chk("rnd.active", active, e_act);
            chk("rnd.busy", busy, bz);

            e_vld = (ic >= 0);
            for (int i = 0; i < N; i++) if (rsp[i]) m_act[i] = 0;
            if (ic >= 0) begin
                ent = mq[ic].pop_front();
                e_eng = ent.eng; e_op = op_of(ic);
                if (ic == 0) e_dat = ent.dat;
                m_act[ent.eng] = 1;
                m_cptr = (ic + 1) % 3;
            end
            if (g >= 0) begin
                ent.eng = g; ent.dat = cmd_dat[g];
                mq[gc].push_back(ent);
                m_eptr = (g + 1) % N;
            end
        end
        tick(); idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
